// File: rtl/cam_framebuf_ctrl_if.sv
// Frame-buffer SRAM bus: the controller (master) drives address, write
// enable and write data; the single-port synchronous SRAM (slave) returns
// read data one cycle after the address is presented.
interface cam_framebuf_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/cam_framebuf_ctrl.sv
// Camera capture controller and frame-buffer arbiter.
// Assembles pairs of camera bytes into RGB565 pixels, addresses them into a
// WIDTH x HEIGHT frame, queues {addr, pixel} in a small FIFO and shares one
// single-port SRAM with the VGA reader, which always wins the slot.
module cam_framebuf_ctrl #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic              cam_vref,
    input  logic              cam_href,
    input  logic              cam_valid,
    input  logic [7:0]        cam_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [15:0]       rd_data,
    cam_framebuf_ctrl_if.master mem,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    localparam int COL_W   = ADDR_W + 1;
    localparam int LINE_W  = $clog2(HEIGHT + 1);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENTRY_W = ADDR_W + 16;

    localparam logic [COL_W-1:0]  WIDTH_C   = COL_W'(WIDTH);
    localparam logic [ADDR_W-1:0] WIDTH_A   = ADDR_W'(WIDTH);
    localparam logic [LINE_W-1:0] HEIGHT_L  = LINE_W'(HEIGHT);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(HEIGHT - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE
    } state_t;

    state_t state;

    logic vref_q, vref_qq;
    logic href_q, href_qq;

    logic              phase;
    logic [7:0]        hi_byte;
    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;
    logic [ADDR_W-1:0] base;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;

    logic rd_p1, rd_p2;

    logic              vref_rise, href_rise, href_fall;
    logic              in_capture, byte_ok, pix_done, in_range;
    logic              fifo_full, fifo_empty, push, pop, drop_full, frame_end;
    logic [ADDR_W-1:0] pix_addr;

    assign busy = (state != IDLE);

    // Edge detection, pixel completion and FIFO/arbiter handshakes.
    always_comb begin
        vref_rise  = vref_q & ~vref_qq;
        href_rise  = href_q & ~href_qq;
        href_fall  = ~href_q & href_qq;
        in_capture = (state == CAPTURE);
        frame_end  = in_capture & (vref_rise | (href_fall & (line == LAST_LINE)));
        byte_ok    = in_capture & ~vref_rise & href_q & cam_valid;
        // A byte coinciding with the href rise always starts a new pixel.
        pix_done   = byte_ok & phase & ~href_rise;
        in_range   = (col < WIDTH_C) & (line < HEIGHT_L);
        pix_addr   = base + col[ADDR_W-1:0];
        fifo_full  = (count == DEPTH_C);
        fifo_empty = (count == '0);
        push       = pix_done & in_range & ~fifo_full;
        drop_full  = pix_done & in_range & fifo_full;
        pop        = ~rd_req & ~fifo_empty;
    end

    // Register the camera sync lines once; edges compare against this copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vref_q  <= 1'b0;
            vref_qq <= 1'b0;
            href_q  <= 1'b0;
            href_qq <= 1'b0;
        end else begin
            vref_q  <= cam_vref;
            vref_qq <= vref_q;
            href_q  <= cam_href;
            href_qq <= href_q;
        end
    end

    // Capture FSM: frame sequencing, byte pairing, geometry and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= 1'b0;
            hi_byte    <= '0;
            col        <= '0;
            line       <= '0;
            base       <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= frame_end;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ARMED;
                        overflow <= 1'b0;
                    end
                end
                ARMED: begin
                    if (vref_rise) begin
                        state <= CAPTURE;
                        phase <= 1'b0;
                        col   <= '0;
                        line  <= '0;
                        base  <= '0;
                    end
                end
                CAPTURE: begin
                    if (frame_end) begin
                        phase <= 1'b0;
                        col   <= '0;
                        line  <= '0;
                        base  <= '0;
                        if (!continuous) begin
                            state <= IDLE;
                        end else if (vref_rise) begin
                            state <= CAPTURE;
                        end else begin
                            state <= ARMED;
                        end
                    end else if (href_fall) begin
                        phase <= 1'b0;
                        col   <= '0;
                        line  <= line + 1'b1;
                        base  <= base + WIDTH_A;
                    end else if (byte_ok) begin
                        if (pix_done) begin
                            phase <= 1'b0;
                            if (drop_full) begin
                                overflow <= 1'b1;
                            end
                            // Column saturates at WIDTH: everything beyond is dropped anyway.
                            if (col < WIDTH_C) begin
                                col <= col + 1'b1;
                            end
                        end else begin
                            hi_byte <= cam_data;
                            phase   <= 1'b1;
                        end
                    end else if (href_rise) begin
                        phase <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pix_addr, hi_byte, cam_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // SRAM slot arbitration (read first) and fixed-latency read return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem.mem_addr  <= '0;
            mem.mem_we    <= 1'b0;
            mem.mem_wdata <= '0;
            rd_p1         <= 1'b0;
            rd_p2         <= 1'b0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
        end else begin
            rd_p1    <= rd_req;
            rd_p2    <= rd_p1;
            rd_valid <= rd_p2;
            if (rd_p2) begin
                rd_data <= mem.mem_rdata;
            end
            if (rd_req) begin
                mem.mem_addr <= rd_addr;
                mem.mem_we   <= 1'b0;
            end else if (!fifo_empty) begin
                {mem.mem_addr, mem.mem_wdata} <= fifo_mem[rd_ptr];
                mem.mem_we <= 1'b1;
            end else begin
                mem.mem_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cam_framebuf_ctrl.sv
// Directed bench for cam_framebuf_ctrl: SRAM model with write log, read
// latency, frame sequencing, overflow, line clipping, continuous mode and
// mid-frame reset.
module tb_cam_framebuf_ctrl;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          continuous;
    logic          cam_vref;
    logic          cam_href;
    logic          cam_valid;
    logic [7:0]    cam_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [15:0]   rd_data;
    logic          busy;
    logic          frame_done;
    logic          overflow;
    logic          preload;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt   = 0;

    logic [15:0]   sram [2**AW];
    logic [AW-1:0] wr_addr_q [$];
    logic [15:0]   wr_data_q [$];

    cam_framebuf_ctrl_if #(.ADDR_W(AW)) mem_bus ();

    cam_framebuf_ctrl #(
        .WIDTH(320),
        .HEIGHT(2),
        .ADDR_W(AW),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .continuous(continuous),
        .cam_vref(cam_vref),
        .cam_href(cam_href),
        .cam_valid(cam_valid),
        .cam_data(cam_data),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .mem(mem_bus.master),
        .busy(busy),
        .frame_done(frame_done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Synchronous single-port SRAM model with a log of every write.
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 2**AW; k++) sram[k] <= 16'hC000 + 16'(k);
        end else if (mem_bus.mem_we) begin
            sram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
            wr_addr_q.push_back(mem_bus.mem_addr);
            wr_data_q.push_back(mem_bus.mem_wdata);
        end
        mem_bus.mem_rdata <= sram[mem_bus.mem_addr];
    end

    // Count frame_done pulses.
    always @(posedge clk) begin
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_data  = b;
        cam_valid = 1'b1;
        tick();
    endtask

    task automatic href_on();
        cam_href = 1'b1;
        tick();
        tick();
    endtask

    task automatic line_end();
        cam_valid = 1'b0;
        tick();
        cam_href = 1'b0;
        repeat (4) tick();
    endtask

    task automatic vref_pulse();
        cam_vref = 1'b1;
        repeat (3) tick();
        cam_vref = 1'b0;
        repeat (2) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_fd"},    32'(frame_done), 32'd0);
        check({tag, "_ovf"},   32'(overflow), 32'd0);
        check({tag, "_we"},    32'(mem_bus.mem_we), 32'd0);
        check({tag, "_addr"},  32'(mem_bus.mem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(mem_bus.mem_wdata), 32'd0);
        check({tag, "_rdv"},   32'(rd_valid), 32'd0);
        check({tag, "_rdd"},   32'(rd_data), 32'd0);
    endtask

    logic [7:0]    t1_bytes [16] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
                                     8'h0F, 8'hED, 8'hCB, 8'hA9, 8'h87, 8'h65, 8'h43, 8'h21};
    logic [AW-1:0] t1_addr  [8]  = '{17'd0, 17'd1, 17'd2, 17'd3, 17'd320, 17'd321, 17'd322, 17'd323};
    logic [15:0]   t1_data  [8]  = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                                     16'h0FED, 16'hCBA9, 16'h8765, 16'h4321};
    logic [AW-1:0] t5_addr  [3]  = '{17'd0, 17'd1, 17'd0};
    logic [15:0]   t5_data  [3]  = '{16'h0102, 16'h0304, 16'h0506};

    initial begin
        int base_i;
        int fd0;
        int bad;
        int n;
        logic [7:0] pb;

        reset = 1'b1; preload = 1'b1; start = 1'b0; continuous = 1'b0;
        cam_vref = 1'b0; cam_href = 1'b0; cam_valid = 1'b0; cam_data = '0;
        rd_req = 1'b0; rd_addr = '0;
        repeat (3) tick();
        preload = 1'b0;
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Back-to-back reads of addresses 0..9 from preloaded memory.
        for (int c = 0; c < 14; c++) begin
            rd_req  = (c < 10);
            rd_addr = AW'(c);
            tick();
            check("rd_we", 32'(mem_bus.mem_we), 32'd0);
            if (c < 10) check("rd_addr", 32'(mem_bus.mem_addr), 32'(c));
            check("rd_valid", 32'(rd_valid), ((c + 1 >= 3) && (c + 1 <= 12)) ? 32'd1 : 32'd0);
            if ((c + 1 >= 3) && (c + 1 <= 12))
                check("rd_data", 32'(rd_data), 32'(16'hC000 + 16'(c - 2)));
        end
        rd_req = 1'b0;
        tick();

        // Two lines of four pixels, single-shot frame.
        base_i = wr_addr_q.size();
        fd0    = fd_cnt;
        pulse_start();
        check("t1_busy_armed", 32'(busy), 32'd1);
        vref_pulse();
        href_on();
        for (int i = 0; i < 8; i++) send_byte(t1_bytes[i]);
        line_end();
        check("t1_no_fd_line0", 32'(fd_cnt - fd0), 32'd0);
        href_on();
        for (int i = 8; i < 16; i++) send_byte(t1_bytes[i]);
        cam_valid = 1'b0;
        tick();
        cam_href = 1'b0;
        tick();
        check("t1_fd_f1", 32'(frame_done), 32'd0);
        check("t1_busy_f1", 32'(busy), 32'd1);
        tick();
        check("t1_fd_f2", 32'(frame_done), 32'd1);
        check("t1_busy_f2", 32'(busy), 32'd0);
        tick();
        check("t1_fd_f3", 32'(frame_done), 32'd0);
        repeat (4) tick();
        check("t1_nwrites", 32'(wr_addr_q.size() - base_i), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (base_i + i < wr_addr_q.size()) begin
                check($sformatf("t1_wr%0d_addr", i), 32'(wr_addr_q[base_i + i]), 32'(t1_addr[i]));
                check($sformatf("t1_wr%0d_data", i), 32'(wr_data_q[base_i + i]), 32'(t1_data[i]));
            end
        end

        // Reads hog the SRAM while six pixels arrive; FIFO holds four.
        pulse_start();
        vref_pulse();
        base_i = wr_addr_q.size();
        rd_req  = 1'b1;
        rd_addr = '0;
        href_on();
        for (int i = 0; i < 12; i++) begin
            pb = (i % 2 == 0) ? 8'(8'hA0 + i / 2) : 8'(8'h50 + i / 2);
            send_byte(pb);
            if (i == 7) check("t3_ovf_after4", 32'(overflow), 32'd0);
            if (i == 9) check("t3_ovf_after5", 32'(overflow), 32'd1);
        end
        cam_valid = 1'b0;
        tick();
        check("t3_no_wr_during_rd", 32'(wr_addr_q.size() - base_i), 32'd0);
        rd_req = 1'b0;
        repeat (6) tick();
        check("t3_nwrites", 32'(wr_addr_q.size() - base_i), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (base_i + i < wr_addr_q.size()) begin
                check($sformatf("t3_wr%0d_addr", i), 32'(wr_addr_q[base_i + i]), 32'(i));
                check($sformatf("t3_wr%0d_data", i), 32'(wr_data_q[base_i + i]),
                      32'({8'(8'hA0 + i), 8'(8'h50 + i)}));
            end
        end
        line_end();
        fd0 = fd_cnt;
        vref_pulse();
        check("t3_vref_fd", 32'(fd_cnt - fd0), 32'd1);
        check("t3_idle", 32'(busy), 32'd0);
        check("t3_ovf_sticky", 32'(overflow), 32'd1);
        bad = 0;
        for (int i = base_i; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] == 17'd4 || wr_addr_q[i] == 17'd5) bad++;
        check("t3_addr45_unwritten", 32'(bad), 32'd0);

        // Over-long line with odd trailing byte; next line starts at WIDTH.
        pulse_start();
        check("t4_ovf_cleared", 32'(overflow), 32'd0);
        vref_pulse();
        base_i = wr_addr_q.size();
        href_on();
        for (int p = 0; p < 323; p++) begin
            send_byte(8'(p));
            send_byte(8'(p) ^ 8'hFF);
        end
        send_byte(8'hEE);
        line_end();
        n = wr_addr_q.size() - base_i;
        check("t4_nwrites", 32'(n), 32'd320);
        bad = 0;
        for (int i = 0; i < n; i++)
            if (wr_addr_q[base_i + i] != AW'(i) ||
                wr_data_q[base_i + i] != {8'(i), 8'(i) ^ 8'hFF}) bad++;
        check("t4_bad_entries", 32'(bad), 32'd0);
        base_i = wr_addr_q.size();
        fd0    = fd_cnt;
        href_on();
        send_byte(8'h5A); send_byte(8'hC3); send_byte(8'h11); send_byte(8'h22);
        line_end();
        check("t4_l1_nwrites", 32'(wr_addr_q.size() - base_i), 32'd2);
        if (wr_addr_q.size() - base_i >= 2) begin
            check("t4_l1_addr0", 32'(wr_addr_q[base_i]), 32'd320);
            check("t4_l1_data0", 32'(wr_data_q[base_i]), 32'h5AC3);
            check("t4_l1_addr1", 32'(wr_addr_q[base_i + 1]), 32'd321);
            check("t4_l1_data1", 32'(wr_data_q[base_i + 1]), 32'h1122);
        end
        check("t4_fd", 32'(fd_cnt - fd0), 32'd1);
        check("t4_idle", 32'(busy), 32'd0);

        // Continuous mode: vref mid-frame restarts at address 0, then reset.
        continuous = 1'b1;
        base_i = wr_addr_q.size();
        pulse_start();
        vref_pulse();
        href_on();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        line_end();
        cam_vref = 1'b1;
        tick();
        check("t5_fd_v1", 32'(frame_done), 32'd0);
        tick();
        check("t5_fd_v2", 32'(frame_done), 32'd1);
        check("t5_busy_v2", 32'(busy), 32'd1);
        cam_vref = 1'b0;
        repeat (2) tick();
        href_on();
        send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
        cam_valid = 1'b0;
        check("t5_lat_n1_we", 32'(mem_bus.mem_we), 32'd0);
        tick();
        check("t5_lat_n2_we", 32'(mem_bus.mem_we), 32'd1);
        check("t5_lat_n2_addr", 32'(mem_bus.mem_addr), 32'd1);
        check("t5_lat_n2_data", 32'(mem_bus.mem_wdata), 32'h0708);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t5_async_rst");
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'h90 + 8'(i));
        cam_valid = 1'b0;
        repeat (4) tick();
        check("t5_post_rst_busy", 32'(busy), 32'd0);
        check("t5_post_rst_we", 32'(mem_bus.mem_we), 32'd0);
        check("t5_nwrites", 32'(wr_addr_q.size() - base_i), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (base_i + i < wr_addr_q.size()) begin
                check($sformatf("t5_wr%0d_addr", i), 32'(wr_addr_q[base_i + i]), 32'(t5_addr[i]));
                check($sformatf("t5_wr%0d_data", i), 32'(wr_data_q[base_i + i]), 32'(t5_data[i]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cam_framebuf_ctrl.md
# cam_framebuf_ctrl

Capture controller and single-port frame-buffer arbiter between the camera byte stream (href/vref/8-bit data) and the VGA pixel fetch path. It assembles two camera bytes into one 16-bit RGB565 pixel and sequences a frame into buffer addresses. It shares one single-port synchronous SRAM between the capture writer and the VGA reader, with the VGA reader taking fixed-latency priority. It sits between the camera interface and the VGA controller's colour inputs.

## Interface
Parameters:
- WIDTH, 320, pixels stored per line
- HEIGHT, 240, lines stored per frame
- ADDR_W, 17, frame-buffer address width (WIDTH*HEIGHT must be ≤ 2^ADDR_W)
- FIFO_DEPTH, 4, write-pixel FIFO entries (power of two)

Ports:
- clk  in  1  system clock; all inputs synchronous to it
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; arms capture
- continuous  in  1  level; 1 = re-arm after each frame
- cam_vref  in  1  camera frame sync, active high
- cam_href  in  1  camera line valid, active high
- cam_valid  in  1  one-cycle strobe: cam_data holds a byte
- cam_data  in  8  camera byte
- rd_req  in  1  VGA read request
- rd_addr  in  ADDR_W  VGA read address
- rd_valid  out  1  rd_data valid
- rd_data  out  16  pixel read back
- mem_addr  out  ADDR_W  SRAM address (registered)
- mem_we  out  1  SRAM write enable (registered)
- mem_wdata  out  16  SRAM write data (registered)
- mem_rdata  in  16  SRAM read data, valid the cycle after the address is presented
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse at frame end
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full

## Operation
- Reset values: all outputs 0; state IDLE; FIFO empty; counters 0.
- cam_vref and cam_href are registered once internally; edges are detected against the registered copy, which adds 1 cycle.
- States:
  - IDLE: start → ARMED.
  - ARMED: vref rising edge → CAPTURE; clears line, column, base address and byte phase.
  - CAPTURE: frame ends when the href falling edge completes line HEIGHT-1, or on a vref rising edge, whichever comes first. On frame end, frame_done pulses. Then: continuous=1 → ARMED (a vref rise that ended the frame also starts the next, i.e. goes directly to CAPTURE); else → IDLE.
  - start outside IDLE is ignored.
- Pixel assembly (CAPTURE only, href high):
  - The first cam_valid byte goes to pixel[15:8], the second to pixel[7:0].
  - An href rising edge resets the byte phase to first.
  - A byte arriving while href is low is ignored.
  - An odd trailing byte at the href fall is discarded.
- Addressing:
  - Address = base + column. base += WIDTH on each href falling edge.
  - Pixels with column ≥ WIDTH, or arriving after HEIGHT lines, are dropped without a FIFO push.
  - column increments on every complete pixel, including dropped-for-overflow pixels, so geometry is preserved.
  - Width arithmetic is ADDR_W bits, with no wrap inside a valid frame.
- FIFO: holds {addr, pixel}.
  - Push when a complete in-range pixel is assembled.
  - If the FIFO is full, the pixel is dropped and overflow is set. overflow clears on reset or an accepted start.
- Arbitration, per cycle:
  - rd_req=1: read slot; the write waits.
  - Else, if the FIFO is not empty: pop one entry into a write slot.
  - Reads never stall.
  - A push and pop in the same cycle is legal; occupancy is unchanged.
- The FIFO is not flushed on frame end; queued writes drain in IDLE.
- Reset mid-frame: immediate return to IDLE, FIFO contents lost, mem_we deasserted asynchronously.

## Timing
- Read: rd_req and rd_addr sampled in cycle N → mem_addr driven with mem_we=0 in N+1 → mem_rdata in N+2 registered → rd_valid=1 and rd_data in N+3.
- Back-to-back reads give one result per cycle.
- Write: an entry popped in cycle N gives mem_we=1 with addr/data in N+1 for exactly one cycle.
- Pixel latency: the second byte's cam_valid in cycle N → FIFO push at end of N → earliest mem_we in N+2.
- frame_done: 2 cycles after the terminating cam_href fall or cam_vref rise at the port (1 cycle registering + 1 cycle detect).
- Sustained capture requires free (rd_req=0) cycles to average at least one per completed pixel; otherwise overflow.

## Test plan
- Reset, start=1, continuous=0, 2 lines × 4 pixels with bytes 0x12,0x34,… and rd_req=0 → 8 writes: addr 0..3 = 0x1234, 0x5678, … and addr 320..323 follow; frame_done only after line HEIGHT-1 (use HEIGHT=2 override); busy falls the same cycle.
- rd_req held 1 for 10 cycles, rd_addr = 0..9 → rd_valid for 10 cycles starting 3 cycles later; rd_data equals preloaded mem model; mem_we=0 throughout.
- rd_req=1 continuously while 6 pixels arrive, FIFO_DEPTH=4 → 4 pushes, overflow=1 on pixel 5; after rd_req drops, 4 writes at addr 0..3; addr 4..5 never written.
- Line of WIDTH+3 pixels plus an odd trailing byte → exactly WIDTH writes; next line starts at addr WIDTH, first byte to [15:8].
- continuous=1, vref rises mid-frame → frame_done pulse, new frame restarts at addr 0; assert reset during CAPTURE → all outputs 0 immediately, busy=0, no further mem_we.
